axis_chan_framer: RTL

Frames the merged AXI-stream produced by the channel fan-in stage into self-describing packets for the host link. Each input packet is delimited by `s_axis_tlast` and carries its source channel number on `s_axis_tuser`. The block wraps each packet with a header beat (magic word, channel, per-channel sequence number) and a trailer beat (inverted magic, beat count, optional checksum). It sits directly downstream of the fan-in stage and upstream of the host-interface FIFO.

---
 rtl/axis_framer_pkg.sv | 29 ++
 rtl/axis_framer_csum.sv | 37 +++
 rtl/axis_chan_framer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/axis_framer_pkg.sv
// Shared definitions for the AXI-stream channel framer.
// Holds the FSM state encoding, header/trailer bit-field offsets and the
// default sync word used by axis_chan_framer and axis_framer_csum.
package axis_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        TRL  = 2'd3
    } state_t;

    localparam logic [31:0] MAGIC_DEFAULT = 32'hA55A_0F0F;

    // Header beat fields
    localparam int HDR_MAGIC_LSB = 0;
    localparam int HDR_SEQ_LSB   = 32;
    localparam int HDR_CHAN_LSB  = 48;

    // Trailer beat fields
    localparam int TRL_MAGIC_LSB = 0;
    localparam int TRL_CNT_LSB   = 32;
    localparam int TRL_CSUM_LSB  = 48;

    localparam int MAGIC_W   = 32;
    localparam int FIELD16_W = 16;
    localparam int CHAN_W    = 8;

endpackage

// File: rtl/axis_framer_csum.sv
// Purpose: 16-bit lane-XOR fold of each payload beat plus running accumulator.
// Latency: accumulator updates on the clock edge that accepts the beat.
// Backpressure: none; caller drives en only for accepted beats.
// Ports: clk/rst, clr (restart packet), en (fold dat in), dat, csum (running value).
import axis_framer_pkg::*;

module axis_framer_csum #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] dat,
    output logic [15:0]           csum
);

    localparam int LANES = DATA_WIDTH / FIELD16_W;

    logic [15:0] fold;

    always_comb begin
        fold = '0;
        for (int i = 0; i < LANES; i++) begin
            fold = fold ^ dat[i*FIELD16_W +: FIELD16_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            csum <= '0;
        end else if (en) begin
            csum <= csum ^ fold;
        end
    end

endmodule

// File: rtl/axis_chan_framer.sv
// Purpose: wraps each tuser-tagged AXI-stream packet in a header beat
//   (magic, channel, per-channel sequence) and a trailer beat (~magic, beat count, checksum).
// Latency: 1 cycle per beat (fully registered output); one IDLE cycle between packets.
// Backpressure: s_axis_tready follows the single output register being free
//   (empty or accepted this cycle); outputs hold while m_axis_tready=0.
// Ports: clk, rst (sync, active-high), s_axis_* payload in, m_axis_* framed out.
// Build option: define AXIS_FRAMER_CSUM_EN to fill trailer [63:48] with the lane-XOR checksum.
import axis_framer_pkg::*;

module axis_chan_framer #(
    parameter int          NUM_CHAN   = 6,
    parameter int          DATA_WIDTH = 256,
    parameter int          SEQ_WIDTH  = 16,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] MAGIC      = MAGIC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [NUM_CHAN-1:0]   s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);

    localparam int                  IDX_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [NUM_CHAN-1:0] CHAN_LIM = NUM_CHAN[NUM_CHAN-1:0];

    state_t                  state;
    logic [NUM_CHAN-1:0]     chan;
    logic [NUM_CHAN-1:0]     trl_chan;
    logic                    trl_inc;
    logic [SEQ_WIDTH-1:0]    seq [NUM_CHAN];
    logic [CNT_WIDTH-1:0]    beat_cnt;
    logic [15:0]             csum_val;

    logic                    out_free;
    logic                    chan_ok;
    logic                    trl_acc;
    logic                    beat_acc;
    logic [SEQ_WIDTH-1:0]    seq_hdr;
    logic [DATA_WIDTH-1:0]   hdr_beat;
    logic [DATA_WIDTH-1:0]   trl_beat;

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && (state == DATA) && out_free;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign chan_ok       = (chan < CHAN_LIM);
    assign trl_acc       = m_axis_tvalid && m_axis_tlast && m_axis_tready;

    // A stalled trailer for the same channel can be accepted in the very cycle
    // the next header loads; forward that increment so the header is not stale.
    always_comb begin
        seq_hdr = '0;
        if (chan_ok) begin
            seq_hdr = seq[chan[IDX_W-1:0]];
            if (trl_acc && trl_inc && (trl_chan == chan)) begin
                seq_hdr = seq_hdr + SEQ_WIDTH'(1);
            end
        end
    end

    always_comb begin
        hdr_beat = '0;
        hdr_beat[HDR_MAGIC_LSB +: MAGIC_W]   = MAGIC;
        hdr_beat[HDR_SEQ_LSB +: FIELD16_W]   = 16'(seq_hdr);
        hdr_beat[HDR_CHAN_LSB +: CHAN_W]     = 8'(chan);
    end

    always_comb begin
        trl_beat = '0;
        trl_beat[TRL_MAGIC_LSB +: MAGIC_W]   = ~MAGIC;
        trl_beat[TRL_CNT_LSB +: FIELD16_W]   = 16'(beat_cnt);
        trl_beat[TRL_CSUM_LSB +: FIELD16_W]  = csum_val;
    end

`ifdef AXIS_FRAMER_CSUM_EN
    axis_framer_csum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE) && s_axis_tvalid),
        .en   (beat_acc),
        .dat  (s_axis_tdata),
        .csum (csum_val)
    );
`else
    assign csum_val = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            chan          <= '0;
            trl_chan      <= '0;
            trl_inc       <= 1'b0;
            beat_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                seq[i] <= '0;
            end
        end else begin
            if (trl_acc && trl_inc) begin
                seq[trl_chan[IDX_W-1:0]] <= seq[trl_chan[IDX_W-1:0]] + SEQ_WIDTH'(1);
            end

            // Drop valid on acceptance; any load below overrides this.
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        chan     <= s_axis_tuser;
                        beat_cnt <= '0;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= hdr_beat;
                        m_axis_tlast  <= 1'b0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (beat_acc) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tlast  <= 1'b0;
                        if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                        if (s_axis_tlast) begin
                            state <= TRL;
                        end
                    end
                end
                TRL: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= trl_beat;
                        m_axis_tlast  <= 1'b1;
                        trl_chan      <= chan;
                        trl_inc       <= chan_ok;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
